y86_execute_stage: RTL and testbench
====================================

# y86_execute_stage

Parametrised Y86-64 pipeline execute stage with a registered E→M pipeline register, architectural condition-code register and stall/bubble control. Computes valE and Cnd from decoded E-stage operands, updates ZF/SF/OF only for committed OPq instructions, and gates it against exceptions in later stages. Sits between the decode/E register and the memory stage in the pipelined processor. Optionally includes an iterative multiplier behind a busy handshake.

## Interface
- WIDTH, 64, data-path width in bits (≥8)
- MUL_CNT_W, 7, width of the multiply cycle counter; must satisfy 2^MUL_CNT_W > WIDTH
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- E_valid  in  1  E register holds an instruction
- E_stat  in  3  status: 1 AOK, 2 HLT, 3 ADR, 4 INS
- E_icode, E_ifun  in  4 each  instruction code and function
- E_valA, E_valB, E_valC  in  WIDTH each  operands
- E_dstE, E_dstM  in  4 each  destination registers; 0xF = RNONE
- m_stat_bad, W_stat_bad  in  1 each  exception in the memory or writeback stage
- M_stall, M_bubble  in  1 each  hold or clear the M register
- e_ready  out  1  E instruction is consumed at this edge
- e_valE  out  WIDTH  combinational ALU result (forwarding path)
- e_dstE  out  4  E_dstE, or 0xF for a not-taken cmov
- e_Cnd  out  1  combinational condition result
- cc  out  3  {ZF,SF,OF} register
- M_valid, M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM  out  registered copies of the E-stage values

## Operation
- valE by icode:
  - 2 cmov: valA
  - 3 irmovq: valC
  - 4/5 rmmovq/mrmovq: valB+valC
  - 6 OPq: valB op valA, with ifun 0 add, 1 sub (valB−valA), 2 and, 3 xor
  - 8/A call/pushq: valB−8
  - 9/B ret/popq: valB+8
  - all other icodes: 0
- All arithmetic is modulo 2^WIDTH, two's complement.
- CC from an OPq result:
  - ZF = (res==0)
  - SF = res[WIDTH-1]
  - OF for add = operands share a sign and the result sign differs
  - OF for sub = valB and valA differ in sign and res sign ≠ valB sign
  - OF for and/xor = 0
- Cnd for icode 2/7 uses the cc register. ifun encoding:
  - 0 always
  - 1 le: (SF^OF)|ZF
  - 2 l: SF^OF
  - 3 e: ZF
  - 4 ne: ~ZF
  - 5 ge: ~(SF^OF)
  - 6 g: ~(SF^OF)&~ZF
  - ifun>6: Cnd=0
  - other icodes: Cnd=0
- cc update condition: all of E_valid, icode 6, E_stat==AOK, e_ready, !m_stat_bad, !W_stat_bad.
- OPq with ifun>3 (ifun>4 with macro) is illegal:
  - M_stat=4 (INS)
  - valE=0
  - no cc update
- M register precedence:
  - M_stall=1: hold (M_stall wins over M_bubble)
  - else M_bubble=1 or !e_ready: load bubble (M_valid=0, icode 0, stat 1, dstE/dstM 0xF, Cnd 0, data 0)
  - else load E values
  - e_ready=0 whenever M_stall=1

## Timing
- Non-multiply instructions: e_* outputs combinational in the same cycle; M_* valid one edge later; cc new value visible the cycle after the OPq edge.
- An OPq followed directly by jXX/cmov sees the updated cc.
- Reset (asynchronous, rst_n low) forces:
  - cc = {1,0,0}
  - M register = bubble
  - multiply FSM = IDLE, counter = 0
  - e_ready and the other combinational outputs follow their inputs.
- Reset mid-multiply abandons the operation; nothing is written.

## Configuration
- EXEC_IMUL_EN defined: OPq ifun 4 = signed multiply, low WIDTH bits of valB×valA, computed iteratively.
  - FSM states:
    - IDLE → MUL on a valid AOK mul in E with M_stall=0
    - MUL runs WIDTH shift-add cycles
    - MUL → DONE when the count reaches WIDTH
    - DONE → IDLE at the edge that loads M
  - e_ready=0 in IDLE-with-mul and MUL, =1 in DONE (and M_stall=0).
  - Upstream must hold E inputs stable while e_ready=0.
  - Result reaches M at edge WIDTH+1 after arrival.
  - cc: ZF/SF from the product, OF=0, with the normal suppression rules.
  - Exceptions raised during MUL do not abort it; they only suppress the cc update.
- EXEC_IMUL_EN undefined: ifun 4 is illegal (INS); e_ready = !M_stall always; no FSM logic is present.

## Test plan
- OPq add, WIDTH=64, valA=0x7FFF_FFFF_FFFF_FFFF, valB=1 → M_valE=0x8000_0000_0000_0000, cc={0,1,1} after the edge.
- OPq sub, valA=5, valB=5, then jXX ifun 3 (je) next cycle → cc={1,0,0}, e_Cnd=1; cmov ifun 4 → e_dstE=0xF.
- OPq with m_stat_bad=1 → M loads the result, cc unchanged from reset {1,0,0}.
- M_stall and M_bubble both asserted for 2 cycles → M_* hold, e_ready=0; M_bubble alone → M_valid=0, M_dstE=0xF.
- EXEC_IMUL_EN, valA=−3, valB=7 → e_ready low 64 cycles, M_valE=0xFFFF_FFFF_FFFF_FFEB at edge 65, cc={0,1,0}; rst_n pulse at cycle 20 → M bubble, FSM IDLE.
- Without EXEC_IMUL_EN, OPq ifun 4 → M_stat=4, M_valE=0, cc unchanged, e_ready=1.

Source files
------------

// File: rtl/y86_execute_stage.sv
// y86_execute_stage: Y86-64 execute stage (ALU, CC register, branch/cmov condition, E->M register).
// Latency: e_* combinational, M_* one edge later; multiply reaches M at edge WIDTH+1 after arrival.
// Backpressure: e_ready low under M_stall or while the multiplier is busy; M then holds or loads a bubble.
// Optional feature macro: EXEC_IMUL_EN adds OPq ifun 4 (signed multiply, iterative shift-add).
module y86_execute_stage #(
  parameter int WIDTH     = 64,
  parameter int MUL_CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             E_valid,
  input  logic [2:0]       E_stat,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_ifun,
  input  logic [WIDTH-1:0] E_valA,
  input  logic [WIDTH-1:0] E_valB,
  input  logic [WIDTH-1:0] E_valC,
  input  logic [3:0]       E_dstE,
  input  logic [3:0]       E_dstM,
  input  logic             m_stat_bad,
  input  logic             W_stat_bad,
  input  logic             M_stall,
  input  logic             M_bubble,
  output logic             e_ready,
  output logic [WIDTH-1:0] e_valE,
  output logic [3:0]       e_dstE,
  output logic             e_Cnd,
  output logic [2:0]       cc,
  output logic             M_valid,
  output logic [2:0]       M_stat,
  output logic [3:0]       M_icode,
  output logic             M_Cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM
);
  localparam int MSB = WIDTH - 1;
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_INS = 3'd4;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;
`ifdef EXEC_IMUL_EN
  localparam logic [3:0] ALU_MUL      = 4'd4;
  localparam logic [3:0] OPQ_IFUN_MAX = 4'd4;
`else
  localparam logic [3:0] OPQ_IFUN_MAX = 4'd3;
`endif
  localparam logic [WIDTH-1:0] STACK_STEP = WIDTH'(8);

  // The multiply counter must be able to count up to WIDTH.
  if ((2 ** MUL_CNT_W) <= WIDTH) begin : g_cnt_w_check
    $error("MUL_CNT_W too narrow for WIDTH");
  end

  logic             is_opq;
  logic             op_illegal;
  logic [WIDTH-1:0] alu_res;
  logic             alu_of;
  logic             cond;
  logic             cc_update;
  logic [2:0]       e_stat;

  assign is_opq     = (E_icode == I_OPQ);
  assign op_illegal = is_opq && (E_ifun > OPQ_IFUN_MAX);

`ifdef EXEC_IMUL_EN
  typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_t;
  mul_state_t           mul_state;
  logic [MUL_CNT_W-1:0] mul_cnt;
  logic [WIDTH-1:0]     mul_acc;
  logic [WIDTH-1:0]     mul_cand;
  logic [WIDTH-1:0]     mul_plier;
  logic                 mul_start;

  assign mul_start = E_valid && (E_stat == STAT_AOK) && is_opq && (E_ifun == ALU_MUL);

  // Shift-add multiplier: first partial product taken on the start edge, one bit per edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_state <= MUL_IDLE;
      mul_cnt   <= '0;
      mul_acc   <= '0;
      mul_cand  <= '0;
      mul_plier <= '0;
    end else begin
      case (mul_state)
        MUL_IDLE: begin
          if (mul_start && !M_stall) begin
            mul_acc   <= E_valA[0] ? E_valB : '0;
            mul_cand  <= E_valB << 1;
            mul_plier <= E_valA >> 1;
            mul_cnt   <= MUL_CNT_W'(1);
            mul_state <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          mul_acc   <= mul_plier[0] ? (mul_acc + mul_cand) : mul_acc;
          mul_cand  <= mul_cand << 1;
          mul_plier <= mul_plier >> 1;
          mul_cnt   <= mul_cnt + 1'b1;
          if (mul_cnt == MUL_CNT_W'(WIDTH - 1)) mul_state <= MUL_DONE;
        end
        MUL_DONE: begin
          if (!M_stall) begin
            mul_state <= MUL_IDLE;
            mul_cnt   <= '0;
          end
        end
        default: mul_state <= MUL_IDLE;
      endcase
    end
  end

  // Hold the instruction in E while a multiply is pending or running.
  always_comb begin
    e_ready = !M_stall;
    case (mul_state)
      MUL_IDLE: if (mul_start) e_ready = 1'b0;
      MUL_RUN:  e_ready = 1'b0;
      default:  ;
    endcase
  end
`else
  assign e_ready = !M_stall;
`endif

  // OPq datapath and overflow detection.
  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    case (E_ifun)
      ALU_ADD: begin
        alu_res = E_valB + E_valA;
        alu_of  = (E_valB[MSB] == E_valA[MSB]) && (alu_res[MSB] != E_valB[MSB]);
      end
      ALU_SUB: begin
        alu_res = E_valB - E_valA;
        alu_of  = (E_valB[MSB] != E_valA[MSB]) && (alu_res[MSB] != E_valB[MSB]);
      end
      ALU_AND: alu_res = E_valB & E_valA;
      ALU_XOR: alu_res = E_valB ^ E_valA;
`ifdef EXEC_IMUL_EN
      ALU_MUL: alu_res = mul_acc;
`endif
      default: ;
    endcase
  end

  // valE selection by instruction class.
  always_comb begin
    e_valE = '0;
    case (E_icode)
      I_CMOV:           e_valE = E_valA;
      I_IRMOV:          e_valE = E_valC;
      I_RMMOV, I_MRMOV: e_valE = E_valB + E_valC;
      I_OPQ:            e_valE = op_illegal ? '0 : alu_res;
      I_CALL, I_PUSH:   e_valE = E_valB - STACK_STEP;
      I_RET, I_POP:     e_valE = E_valB + STACK_STEP;
      default:          ;
    endcase
  end

  // Branch/cmov condition from the architectural cc register {ZF,SF,OF}.
  always_comb begin
    cond = 1'b0;
    case (E_ifun)
      4'd0: cond = 1'b1;
      4'd1: cond = (cc[1] ^ cc[0]) | cc[2];
      4'd2: cond = cc[1] ^ cc[0];
      4'd3: cond = cc[2];
      4'd4: cond = ~cc[2];
      4'd5: cond = ~(cc[1] ^ cc[0]);
      4'd6: cond = ~(cc[1] ^ cc[0]) & ~cc[2];
      default: cond = 1'b0;
    endcase
  end

  assign e_Cnd  = ((E_icode == I_CMOV) || (E_icode == I_JXX)) ? cond : 1'b0;
  assign e_dstE = ((E_icode == I_CMOV) && !e_Cnd) ? RNONE : E_dstE;
  assign e_stat = (op_illegal && (E_stat == STAT_AOK)) ? STAT_INS : E_stat;

  assign cc_update = E_valid && is_opq && !op_illegal && (E_stat == STAT_AOK) && e_ready
                     && !m_stat_bad && !W_stat_bad;

  // Condition codes change only for a committed, legal OPq with no exception downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc <= 3'b100;
    end else if (cc_update) begin
      cc <= {(alu_res == '0), alu_res[MSB], alu_of};
    end
  end

  // E->M pipeline register: stall holds, bubble or unconsumed E inserts a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      M_valid <= 1'b0;
      M_stat  <= STAT_AOK;
      M_icode <= 4'h0;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else if (!M_stall) begin
      if (M_bubble || !e_ready) begin
        M_valid <= 1'b0;
        M_stat  <= STAT_AOK;
        M_icode <= 4'h0;
        M_Cnd   <= 1'b0;
        M_valE  <= '0;
        M_valA  <= '0;
        M_dstE  <= RNONE;
        M_dstM  <= RNONE;
      end else begin
        M_valid <= E_valid;
        M_stat  <= e_stat;
        M_icode <= E_icode;
        M_Cnd   <= e_Cnd;
        M_valE  <= e_valE;
        M_valA  <= E_valA;
        M_dstE  <= e_dstE;
        M_dstM  <= E_dstM;
      end
    end
  end
endmodule

// File: tb/tb_y86_execute_stage.sv
// tb_y86_execute_stage: vector table plus hand sequences for stall/bubble, exceptions and multiply.
// Expected M-register contents are queued when an instruction is driven and compared after its edge.
// Multiply checks are compiled in when EXEC_IMUL_EN is defined; otherwise ifun 4 is checked as illegal.
`timescale 1ns/1ps
module tb_y86_execute_stage;
  localparam int W = 64;

  typedef struct {
    logic         vld;
    logic [2:0]   stat;
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [3:0]   dste;
    logic [W-1:0] x_vale;
    logic         x_cnd;
    logic [3:0]   x_dste;
    logic [2:0]   x_mstat;
    logic [2:0]   x_cc;
  } vec_t;

  typedef struct {
    logic         vld;
    logic [2:0]   stat;
    logic [3:0]   icode;
    logic         cnd;
    logic [W-1:0] vale;
    logic [W-1:0] vala;
    logic [3:0]   dste;
    logic [3:0]   dstm;
  } mrec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         E_valid = 1'b0;
  logic [2:0]   E_stat = 3'd1;
  logic [3:0]   E_icode = 4'h1;
  logic [3:0]   E_ifun = 4'h0;
  logic [W-1:0] E_valA = '0;
  logic [W-1:0] E_valB = '0;
  logic [W-1:0] E_valC = '0;
  logic [3:0]   E_dstE = 4'hF;
  logic [3:0]   E_dstM = 4'hF;
  logic         m_stat_bad = 1'b0;
  logic         W_stat_bad = 1'b0;
  logic         M_stall = 1'b0;
  logic         M_bubble = 1'b0;
  logic         e_ready;
  logic [W-1:0] e_valE;
  logic [3:0]   e_dstE;
  logic         e_Cnd;
  logic [2:0]   cc;
  logic         M_valid;
  logic [2:0]   M_stat;
  logic [3:0]   M_icode;
  logic         M_Cnd;
  logic [W-1:0] M_valE;
  logic [W-1:0] M_valA;
  logic [3:0]   M_dstE;
  logic [3:0]   M_dstM;

  int    checks = 0;
  int    errors = 0;
  mrec_t sb[$];
  mrec_t last_m;
  vec_t  vecs[$];

  always #5 clk = ~clk;

  y86_execute_stage #(.WIDTH(W), .MUL_CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .E_valid(E_valid), .E_stat(E_stat), .E_icode(E_icode),
    .E_ifun(E_ifun), .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC), .E_dstE(E_dstE),
    .E_dstM(E_dstM), .m_stat_bad(m_stat_bad), .W_stat_bad(W_stat_bad), .M_stall(M_stall),
    .M_bubble(M_bubble), .e_ready(e_ready), .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
    .cc(cc), .M_valid(M_valid), .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic vld, input logic [2:0] st, input logic [3:0] ic,
                              input logic [3:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] c, input logic [3:0] de, input logic [W-1:0] xv,
                              input logic xc, input logic [3:0] xd, input logic [2:0] xs,
                              input logic [2:0] xcc);
    vec_t v;
    v.vld = vld; v.stat = st; v.icode = ic; v.ifun = fn; v.a = a; v.b = b; v.c = c; v.dste = de;
    v.x_vale = xv; v.x_cnd = xc; v.x_dste = xd; v.x_mstat = xs; v.x_cc = xcc;
    return v;
  endfunction

  function automatic mrec_t bubble_rec();
    mrec_t r;
    r.vld = 1'b0; r.stat = 3'd1; r.icode = 4'h0; r.cnd = 1'b0;
    r.vale = '0; r.vala = '0; r.dste = 4'hF; r.dstm = 4'hF;
    return r;
  endfunction

  task automatic check_m(input string tag);
    mrec_t r;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
      return;
    end
    r = sb.pop_front();
    chk({tag, " M_valid"}, W'(M_valid), W'(r.vld));
    chk({tag, " M_stat"},  W'(M_stat),  W'(r.stat));
    chk({tag, " M_icode"}, W'(M_icode), W'(r.icode));
    chk({tag, " M_Cnd"},   W'(M_Cnd),   W'(r.cnd));
    chk({tag, " M_valE"},  M_valE,      r.vale);
    chk({tag, " M_valA"},  M_valA,      r.vala);
    chk({tag, " M_dstE"},  W'(M_dstE),  W'(r.dste));
    chk({tag, " M_dstM"},  W'(M_dstM),  W'(r.dstm));
  endtask

  // Called just after a rising edge: drives one instruction and checks it through to M and cc.
  task automatic run_vec(input vec_t v, input logic mbad, input logic wbad, input string tag);
    mrec_t r;
    E_valid = v.vld; E_stat = v.stat; E_icode = v.icode; E_ifun = v.ifun;
    E_valA = v.a; E_valB = v.b; E_valC = v.c; E_dstE = v.dste; E_dstM = 4'h9;
    M_stall = 1'b0; M_bubble = 1'b0; m_stat_bad = mbad; W_stat_bad = wbad;
    @(negedge clk);
    chk({tag, " e_valE"},  e_valE,       v.x_vale);
    chk({tag, " e_Cnd"},   W'(e_Cnd),    W'(v.x_cnd));
    chk({tag, " e_dstE"},  W'(e_dstE),   W'(v.x_dste));
    chk({tag, " e_ready"}, W'(e_ready),  W'(1'b1));
    r.vld = v.vld; r.stat = v.x_mstat; r.icode = v.icode; r.cnd = v.x_cnd;
    r.vale = v.x_vale; r.vala = v.a; r.dste = v.x_dste; r.dstm = 4'h9;
    sb.push_back(r);
    last_m = r;
    @(posedge clk); #1;
    check_m(tag);
    chk({tag, " cc"}, W'(cc), W'(v.x_cc));
    m_stat_bad = 1'b0; W_stat_bad = 1'b0;
  endtask

`ifdef EXEC_IMUL_EN
  // Waits out a multiply already sitting in E and checks its latency and result.
  task automatic mul_finish(input logic [W-1:0] a, input logic [W-1:0] exp, input string tag);
    int    low;
    mrec_t r;
    low = 0;
    @(negedge clk);
    while (e_ready !== 1'b1 && low < 200) begin
      low++;
      @(negedge clk);
    end
    chk({tag, " busy cycles"}, W'(low), W'(64));
    chk({tag, " e_valE"}, e_valE, exp);
    r.vld = 1'b1; r.stat = 3'd1; r.icode = 4'h6; r.cnd = 1'b0;
    r.vale = exp; r.vala = a; r.dste = 4'h3; r.dstm = 4'h9;
    sb.push_back(r);
    @(posedge clk); #1;
    check_m(tag);
    chk({tag, " cc"}, W'(cc), W'(3'b010));
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset cc", W'(cc), W'(3'b100));
    sb.push_back(bubble_rec());
    check_m("reset");
    chk("reset e_ready", W'(e_ready), W'(1'b1));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Exceptions downstream: M still loads, cc stays at its reset value.
    run_vec(mk(1'b1, 3'd1, 4'h6, 4'h0, 64'd1, 64'd2, 64'd0, 4'h3, 64'd3, 1'b0, 4'h3, 3'd1, 3'b100),
            1'b1, 1'b0, "mbad");
    run_vec(mk(1'b1, 3'd1, 4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 4'h3, {W{1'b1}}, 1'b0, 4'h3, 3'd1, 3'b100),
            1'b0, 1'b1, "wbad");

    vecs.push_back(mk(1'b1, 3'd1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h3, 64'h8000_0000_0000_0000, 1'b0, 4'h3, 3'd1, 3'b011));
    vecs.push_back(mk(1'b1, 3'd1, 4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 4'hF, 64'd0, 1'b0, 4'hF, 3'd1, 3'b011));
    vecs.push_back(mk(1'b1, 3'd1, 4'h7, 4'h5, 64'd0, 64'd0, 64'd0, 4'hF, 64'd0, 1'b1, 4'hF, 3'd1, 3'b011));
    vecs.push_back(mk(1'b1, 3'd1, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h4, 64'd0, 1'b0, 4'h4, 3'd1, 3'b100));
    vecs.push_back(mk(1'b1, 3'd1, 4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 4'hF, 64'd0, 1'b1, 4'hF, 3'd1, 3'b100));
    vecs.push_back(mk(1'b1, 3'd1, 4'h2, 4'h4, 64'h1234, 64'd0, 64'd0, 4'h2, 64'h1234, 1'b0, 4'hF, 3'd1, 3'b100));
    vecs.push_back(mk(1'b1, 3'd1, 4'h2, 4'h0, 64'hABC, 64'd0, 64'd0, 4'h5, 64'hABC, 1'b1, 4'h5, 3'd1, 3'b100));
    vecs.push_back(mk(1'b1, 3'd1, 4'h3, 4'h0, 64'd0, 64'd0, 64'hDEAD, 4'h6, 64'hDEAD, 1'b0, 4'h6, 3'd1, 3'b100));
    vecs.push_back(mk(1'b1, 3'd1, 4'h4, 4'h0, 64'd0, 64'h100, 64'h10, 4'hF, 64'h110, 1'b0, 4'hF, 3'd1, 3'b100));
    vecs.push_back(mk(1'b1, 3'd1, 4'h5, 4'h0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 4'hF, 64'h10, 1'b0, 4'hF, 3'd1, 3'b100));
    vecs.push_back(mk(1'b1, 3'd1, 4'hA, 4'h0, 64'd0, 64'h200, 64'd0, 4'h4, 64'h1F8, 1'b0, 4'h4, 3'd1, 3'b100));
    vecs.push_back(mk(1'b1, 3'd1, 4'hB, 4'h0, 64'd0, 64'h200, 64'd0, 4'h4, 64'h208, 1'b0, 4'h4, 3'd1, 3'b100));
    vecs.push_back(mk(1'b1, 3'd1, 4'h8, 4'h0, 64'd0, 64'd0, 64'd0, 4'h4, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 4'h4, 3'd1, 3'b100));
    vecs.push_back(mk(1'b1, 3'd1, 4'h9, 4'h0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 4'h4, 64'd0, 1'b0, 4'h4, 3'd1, 3'b100));
    vecs.push_back(mk(1'b1, 3'd1, 4'h6, 4'h3, {W{1'b1}}, 64'd0, 64'd0, 4'h1, {W{1'b1}}, 1'b0, 4'h1, 3'd1, 3'b010));
    vecs.push_back(mk(1'b1, 3'd1, 4'h7, 4'h1, 64'd0, 64'd0, 64'd0, 4'hF, 64'd0, 1'b1, 4'hF, 3'd1, 3'b010));
    vecs.push_back(mk(1'b1, 3'd1, 4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 4'h2, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 4'h2, 3'd1, 3'b001));
    vecs.push_back(mk(1'b1, 3'd1, 4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 4'hF, 64'd0, 1'b0, 4'hF, 3'd1, 3'b001));
    vecs.push_back(mk(1'b1, 3'd1, 4'h7, 4'h7, 64'd0, 64'd0, 64'd0, 4'hF, 64'd0, 1'b0, 4'hF, 3'd1, 3'b001));
    vecs.push_back(mk(1'b1, 3'd1, 4'h2, 4'h2, 64'h77, 64'd0, 64'd0, 4'h5, 64'h77, 1'b1, 4'h5, 3'd1, 3'b001));
    vecs.push_back(mk(1'b1, 3'd1, 4'h6, 4'h2, 64'hF0, 64'h0F, 64'd0, 4'h1, 64'd0, 1'b0, 4'h1, 3'd1, 3'b100));
    vecs.push_back(mk(1'b1, 3'd1, 4'h6, 4'h0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 4'h1, 64'd0, 1'b0, 4'h1, 3'd1, 3'b101));
    vecs.push_back(mk(1'b1, 3'd1, 4'h7, 4'h1, 64'd0, 64'd0, 64'd0, 4'hF, 64'd0, 1'b1, 4'hF, 3'd1, 3'b101));
    vecs.push_back(mk(1'b1, 3'd1, 4'h6, 4'h5, 64'd1, 64'd2, 64'd0, 4'h3, 64'd0, 1'b0, 4'h3, 3'd4, 3'b101));
    vecs.push_back(mk(1'b1, 3'd2, 4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h3, 64'd2, 1'b0, 4'h3, 3'd2, 3'b101));
    vecs.push_back(mk(1'b0, 3'd1, 4'h6, 4'h3, {W{1'b1}}, 64'd0, 64'd0, 4'h1, {W{1'b1}}, 1'b0, 4'h1, 3'd1, 3'b101));
    vecs.push_back(mk(1'b1, 3'd1, 4'h6, 4'h1, 64'd3, 64'd1, 64'd0, 4'h2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 4'h2, 3'd1, 3'b010));
    vecs.push_back(mk(1'b1, 3'd1, 4'h7, 4'h4, 64'd0, 64'd0, 64'd0, 4'hF, 64'd0, 1'b1, 4'hF, 3'd1, 3'b010));
    vecs.push_back(mk(1'b1, 3'd1, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 64'd0, 1'b0, 4'hF, 3'd1, 3'b010));

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], 1'b0, 1'b0, $sformatf("vec%0d", i));
    end

    // Stall and bubble together: M holds, E not consumed, cc not touched by the waiting OPq.
    E_valid = 1'b1; E_stat = 3'd1; E_icode = 4'h6; E_ifun = 4'h0;
    E_valA = 64'd1; E_valB = 64'd1; E_dstE = 4'h3;
    M_stall = 1'b1; M_bubble = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d e_ready", k), W'(e_ready), W'(1'b0));
      sb.push_back(last_m);
      @(posedge clk); #1;
      check_m($sformatf("stall%0d", k));
      chk($sformatf("stall%0d cc", k), W'(cc), W'(3'b010));
    end
    M_stall = 1'b0;
    E_icode = 4'h3; E_valC = 64'h55;
    @(negedge clk);
    chk("bubble e_ready", W'(e_ready), W'(1'b1));
    sb.push_back(bubble_rec());
    @(posedge clk); #1;
    check_m("bubble");
    M_bubble = 1'b0;

`ifdef EXEC_IMUL_EN
    E_valid = 1'b1; E_stat = 3'd1; E_icode = 4'h6; E_ifun = 4'h4;
    E_valA = 64'hFFFF_FFFF_FFFF_FFFD; E_valB = 64'd7; E_dstE = 4'h3; E_dstM = 4'h9;
    mul_finish(64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, "mul1");
    run_vec(mk(1'b1, 3'd1, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 64'd0, 1'b0, 4'hF, 3'd1, 3'b010),
            1'b0, 1'b0, "after mul");
    E_valid = 1'b1; E_stat = 3'd1; E_icode = 4'h6; E_ifun = 4'h4;
    E_valA = 64'd6; E_valB = 64'hFFFF_FFFF_FFFF_FFFB; E_dstE = 4'h3;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    chk("mul rst cc", W'(cc), W'(3'b100));
    chk("mul rst e_ready", W'(e_ready), W'(1'b0));
    sb.push_back(bubble_rec());
    check_m("mul rst");
    #1 rst_n = 1'b1;
    mul_finish(64'd6, 64'hFFFF_FFFF_FFFF_FFE2, "mul2");
`else
    run_vec(mk(1'b1, 3'd1, 4'h6, 4'h4, 64'd1, 64'd1, 64'd0, 4'h3, 64'd0, 1'b0, 4'h3, 3'd4, 3'b010),
            1'b0, 1'b0, "ifun4");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
